// File: rtl/io_port_pkg.sv
// io_port_pkg: shared window bases, port limit and window-decode helper for io_port_bank
package io_port_pkg;
    localparam int IO_MAX_PORTS = 16;
    localparam logic [7:0] IO_OUT_BASE  = 8'hE0;
    localparam logic [7:0] IO_IN_BASE   = 8'hF0;
    localparam logic [7:0] IO_FLAG_BASE = 8'hD0;
    typedef struct packed {
        logic       hit;
        logic [3:0] off;
    } win_t;
    // An address below base wraps to a huge offset, so one compare covers both bounds.
    function automatic win_t in_window(input logic [31:0] addr, input logic [31:0] base, input logic [31:0] n);
        logic [31:0] d;
        d = addr - base;
        return '{hit: d < n, off: d[3:0]};
    endfunction
endpackage

// File: rtl/io_in_sync.sv
// io_in_sync: one input port's two-flop synchroniser, previous-value register and sticky change flag
// Ports: clk, reset (sync, active-high), pin (async input), clr (flag clear),
//        sync (synchronised value), flag (sticky change flag; a new edge beats clr)
module io_in_sync #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] pin,
    input  logic              clr,
    output logic [DATA_W-1:0] sync,
    output logic              flag
);
    logic [DATA_W-1:0] s1, prev;
    always_ff @(posedge clk) begin
        if (reset) begin
            s1   <= '0;
            sync <= '0;
            prev <= '0;
            flag <= 1'b0;
        end else begin
            s1   <= pin;
            sync <= s1;
            prev <= sync;
            flag <= (sync != prev) || (flag && !clr);
        end
    end
endmodule

// File: rtl/io_port_bank.sv
// io_port_bank: memory-mapped bank of output ports, synchronised input ports, change flags and irq
// Ports: clk, reset (sync, active-high), address/write/data_in (CPU bus), data_out (registered read),
//        port_in/port_out (NUM_PORTS*DATA_W packed pins), irq_en (per-port enable), irq (registered)
// Option: IO_PORT_OUT_READBACK_EN builds the output-window readback mux; otherwise such reads return 0.
module io_port_bank
    import io_port_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int NUM_PORTS = 16,
    parameter int ADDR_W    = 8,
    parameter logic [ADDR_W-1:0] OUT_BASE  = ADDR_W'(IO_OUT_BASE),
    parameter logic [ADDR_W-1:0] IN_BASE   = ADDR_W'(IO_IN_BASE),
    parameter logic [ADDR_W-1:0] FLAG_BASE = ADDR_W'(IO_FLAG_BASE)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [ADDR_W-1:0]           address,
    input  logic                        write,
    input  logic [DATA_W-1:0]           data_in,
    output logic [DATA_W-1:0]           data_out,
    input  logic [NUM_PORTS*DATA_W-1:0] port_in,
    output logic [NUM_PORTS*DATA_W-1:0] port_out,
    input  logic [NUM_PORTS-1:0]        irq_en,
    output logic                        irq
);
    if (NUM_PORTS < 1 || NUM_PORTS > IO_MAX_PORTS) begin : g_bad_n
        $error("io_port_bank: NUM_PORTS out of range");
    end
    if (64'(OUT_BASE) + 64'(NUM_PORTS) > (64'd1 << ADDR_W) ||
        64'(IN_BASE) + 64'(NUM_PORTS) > (64'd1 << ADDR_W) ||
        64'(FLAG_BASE) + 64'(NUM_PORTS) > (64'd1 << ADDR_W)) begin : g_bad_win
        $error("io_port_bank: address window wraps");
    end
    win_t wo, wi, wf;
    logic [IO_MAX_PORTS-1:0][DATA_W-1:0] syn;
    logic [IO_MAX_PORTS-1:0]             flg;
    logic [NUM_PORTS-1:0][DATA_W-1:0]    po;
    logic [DATA_W-1:0]                   rb, rd;
`ifdef IO_PORT_OUT_READBACK_EN
    logic [IO_MAX_PORTS-1:0][DATA_W-1:0] rbk;
`endif
    assign wo = in_window(32'(address), 32'(OUT_BASE), 32'(NUM_PORTS));
    assign wi = in_window(32'(address), 32'(IN_BASE), 32'(NUM_PORTS));
    assign wf = in_window(32'(address), 32'(FLAG_BASE), 32'(NUM_PORTS));
    // Unused slots are tied to zero so the 4-bit window offset indexes a full-size array.
    for (genvar g = 0; g < IO_MAX_PORTS; g++) begin : g_port
        if (g < NUM_PORTS) begin : g_on
            logic [DATA_W-1:0] q;
            io_in_sync #(.DATA_W(DATA_W)) u_sync (
                .clk  (clk),
                .reset(reset),
                .pin  (port_in[g*DATA_W +: DATA_W]),
                .clr  (write && wf.hit && wf.off == 4'(g)),
                .sync (syn[g]),
                .flag (flg[g])
            );
            always_ff @(posedge clk) begin
                if (reset) q <= '0;
                else if (write && wo.hit && wo.off == 4'(g)) q <= data_in;
            end
            assign po[g] = q;
`ifdef IO_PORT_OUT_READBACK_EN
            assign rbk[g] = q;
`endif
        end else begin : g_off
            assign syn[g] = '0;
            assign flg[g] = 1'b0;
`ifdef IO_PORT_OUT_READBACK_EN
            assign rbk[g] = '0;
`endif
        end
    end
`ifdef IO_PORT_OUT_READBACK_EN
    assign rb = wo.hit ? rbk[wo.off] : '0;
`else
    assign rb = '0;
`endif
    assign rd = wi.hit ? syn[wi.off] : wf.hit ? DATA_W'(flg[wf.off]) : rb;
    assign port_out = po;
    always_ff @(posedge clk) begin
        if (reset) begin
            data_out <= '0;
            irq      <= 1'b0;
        end else begin
            data_out <= rd;
            irq      <= |(flg[NUM_PORTS-1:0] & irq_en);
        end
    end
endmodule

// File: tb/tb_io_port_bank.sv
// tb_io_port_bank: directed self-checking bench for io_port_bank (default, 4-port and 12-bit/3-port builds)
module tb_io_port_bank;
    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [7:0]   addr = '0, din = '0, dout, dout4;
    logic         wr = 1'b0, irq, irq4;
    logic [127:0] pin = '0, pout;
    logic [15:0]  en = '0;
    logic [31:0]  pin4 = '0, pout4;
    logic [7:0]   addr12 = '0;
    logic         wr12 = 1'b0, irq12;
    logic [11:0]  din12 = '0, dout12;
    logic [35:0]  pin12 = '0, pout12;
    int total = 0, bad = 0;
`ifdef IO_PORT_OUT_READBACK_EN
    localparam logic [7:0] RB_E2 = 8'hA5;
`else
    localparam logic [7:0] RB_E2 = 8'h00;
`endif

    always #5 clk = ~clk;

    io_port_bank dut (
        .clk(clk), .reset(reset), .address(addr), .write(wr), .data_in(din), .data_out(dout),
        .port_in(pin), .port_out(pout), .irq_en(en), .irq(irq)
    );
    io_port_bank #(.NUM_PORTS(4)) dut4 (
        .clk(clk), .reset(reset), .address(addr), .write(wr), .data_in(din), .data_out(dout4),
        .port_in(pin4), .port_out(pout4), .irq_en(4'b0), .irq(irq4)
    );
    io_port_bank #(.DATA_W(12), .NUM_PORTS(3)) dut12 (
        .clk(clk), .reset(reset), .address(addr12), .write(wr12), .data_in(din12), .data_out(dout12),
        .port_in(pin12), .port_out(pout12), .irq_en(3'b0), .irq(irq12)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        tick(); tick();
        chk("rst_pout", pout, 0);
        chk("rst_irq", {127'd0, irq}, 0);
        chk("rst_dout", dout, 0);
        reset = 1'b0;
        addr = 8'hE0; tick(); chk("rd_e0", dout, 0);
        addr = 8'hF3; tick(); chk("rd_f3", dout, 0);
        addr = 8'hD5; tick(); chk("rd_d5", dout, 0);
        // output write and readback
        addr = 8'hE2; din = 8'hA5; wr = 1'b1; tick(); wr = 1'b0;
        chk("wr_e2_pout", pout, 128'hA5 << 16);
        chk("rdw_old", dout, 0);
        tick(); chk("rb_e2", dout, RB_E2);
        chk("wr_e2_pout4", pout4, 32'h00A5_0000);
        addr = 8'hEF; din = 8'h11; wr = 1'b1; tick(); wr = 1'b0;
        chk("wr_ef_pout4", pout4, 32'h00A5_0000);
        chk("wr_ef_pout", pout, (128'h11 << 120) | (128'hA5 << 16));
        tick(); chk("rd_ef_dut4", dout4, 0);
        // input sync and flag
        en[5] = 1'b1; addr = 8'hF5; pin[47:40] = 8'h3C;
        tick(); chk("in_e1", dout, 0);
        tick(); chk("in_e2", dout, 0);
        tick(); chk("in_e3", dout, 8'h3C);
        chk("irq_e3", {127'd0, irq}, 0);
        addr = 8'hD5; tick();
        chk("flag5", dout, 8'h01);
        chk("irq_e4", {127'd0, irq}, 1);
        // clear racing a new edge: set wins
        pin[47:40] = 8'h5A; tick(); tick();
        wr = 1'b1; tick(); wr = 1'b0;
        tick(); chk("race_flag", dout, 8'h01);
        chk("race_irq", {127'd0, irq}, 1);
        wr = 1'b1; tick(); wr = 1'b0;
        chk("clr_irq_hold", {127'd0, irq}, 1);
        tick();
        chk("clr_flag", dout, 0);
        chk("clr_irq", {127'd0, irq}, 0);
        // change on a port whose interrupt is disabled
        pin[63:56] = 8'h77; addr = 8'hD7;
        repeat (5) tick();
        chk("flag7", dout, 8'h01);
        chk("irq_dis", {127'd0, irq}, 0);
        // reset in the same cycle as a write, with flag[0] set
        en[0] = 1'b1; pin[7:0] = 8'h01;
        repeat (5) tick();
        chk("pre_rst_irq", {127'd0, irq}, 1);
        reset = 1'b1; addr = 8'hE0; din = 8'hFF; wr = 1'b1; tick();
        reset = 1'b0; wr = 1'b0;
        chk("mid_rst_pout", pout, 0);
        chk("mid_rst_irq", {127'd0, irq}, 0);
        addr = 8'hD0; tick(); chk("mid_rst_flag0", dout, 0);
        // 12-bit, 3-port build with loopback
        addr12 = 8'hE1; din12 = 12'hABC; wr12 = 1'b1; tick(); wr12 = 1'b0;
        chk("p12_pout", pout12, 36'h000_ABC_000);
        pin12 = pout12; addr12 = 8'hF1;
        tick(); tick(); tick();
        chk("p12_f1", dout12, 12'hABC);
        addr12 = 8'hD1; tick(); chk("p12_d1", dout12, 12'h001);
        addr12 = 8'hE3; tick(); chk("p12_e3", dout12, 0);
        addr12 = 8'hF3; tick(); chk("p12_f3", dout12, 0);
        addr12 = 8'hD3; tick(); chk("p12_d3", dout12, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
